// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter.
// A small FIFO absorbs producer bursts; a 4-state FSM serialises bytes.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [7:0]    w_head;

  // Transmit engine state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_clk_cnt;
  logic [CW-1:0] w_clk_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          w_bit_end;

  // ready depends only on registered occupancy, never on valid
  assign ready      = (r_count != FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = valid && ready && !rst;
  assign w_head     = r_mem[r_rptr];
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign busy       = !w_empty || (r_state != IDLE);
  assign w_bit_end  = (r_clk_cnt == LAST_CLK);

  // Write accepted bytes into the FIFO array (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  // FIFO pointers and occupancy; push and pop together keep count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit state register; reset aborts any frame at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state, counters, line value and FIFO pop request
  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_bit_nxt   = '0;
          w_clk_nxt   = '0;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_clk_nxt   = '0;
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_clk_nxt = r_clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_clk_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_clk_nxt = r_clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_clk_nxt = '0;
          if (!w_empty) begin
            // chain straight into the next frame, no idle gap
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_bit_nxt   = '0;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clk_nxt   = '0;
        w_bit_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a cycle-exact
// serial receiver checking every sample of every bit.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int errs = 0;
  int nchk = 0;
  int cyc  = 0;

  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  bit         okq[$];
  int         stq[$];

  bit mon = 1'b0;
  int maxc = 0;
  bit stall = 1'b0;
  bit rdy_bad = 1'b0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon) begin
      if (int'(fifo_count) > maxc) maxc <= int'(fifo_count);
      if (ready !== (fifo_count != 3'd4)) rdy_bad <= 1'b1;
      if (ready === 1'b0) stall <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // serial receiver: every one of the CPB samples per bit must agree
  initial begin : rx
    logic [9:0] bits;
    bit bad;
    int t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        t0  = cyc;
        bad = 1'b0;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) bad = 1'b1;
          end
        end
        rxq.push_back(bits[8:1]);
        okq.push_back(!bad && bits[0] == 1'b0 && bits[9] == 1'b1);
        stq.push_back(t0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int t;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    t = 0;
    while (ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("push_timeout", ready, 1);
    @(posedge clk);
    expq.push_back(b);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk({tag, "_idle_to"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rx_cmp(input string tag, input bit agg);
    int nbad;
    nbad = 0;
    chk({tag, "_n"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      if (agg) begin
        if (rxq[i] !== expq[i] || !okq[i]) nbad++;
      end else begin
        chk($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
        chk($sformatf("%s_f%0d", tag, i), okq[i], 1);
      end
    end
    if (agg) chk({tag, "_bad"}, nbad, 0);
    expq.delete();
    rxq.delete();
    okq.delete();
    stq.delete();
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_count, 0);
    rst = 1'b0;

    // single byte, latency and frame length
    push(8'h55);
    @(negedge clk);
    chk("acc_cnt", fifo_count, 1);
    chk("acc_busy", busy, 1);
    chk("acc_tx", tx, 1);
    @(negedge clk);
    chk("lat_tx", tx, 0);
    chk("lat_cnt", fifo_count, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 40);
    chk("end_tx", tx, 1);
    chk("end_cnt", fifo_count, 0);
    wait_idle("one");
    rx_cmp("one", 1'b0);

    // back-to-back with push and pop on the same edge at count 1
    push(8'hA3);
    push(8'h0F);
    @(negedge clk);
    chk("pp_cnt", fifo_count, 1);
    wait_idle("b2b");
    if (stq.size() == 2) chk("b2b_gap", stq[1] - stq[0], 40);
    else chk("b2b_frames", stq.size(), 2);
    rx_cmp("b2b", 1'b0);

    // overfill: ready must drop at 4 and stalled byte waits
    mon = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    push(8'h66);
    mon = 1'b0;
    chk("full_max", maxc, 4);
    chk("full_stall", stall, 1);
    chk("full_ready", rdy_bad, 0);
    wait_idle("full");
    rx_cmp("full", 1'b0);

    // reset during data bit 3 with two bytes queued
    push(8'hC3);
    push(8'h5A);
    push(8'h3C);
    repeat (16) @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'hEE;
    @(negedge clk);
    chk("ab_tx", tx, 1);
    chk("ab_cnt", fifo_count, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", ready, 1);
    rst   = 1'b0;
    valid = 1'b0;
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx === 1'b0) n++;
    end
    chk("ab_nostart", n, 0);
    chk("ab_cnt2", fifo_count, 0);
    expq.delete();
    rxq.delete();
    okq.delete();
    stq.delete();
    push(8'h96);
    wait_idle("post");
    rx_cmp("post", 1'b0);

    // random stream with random gaps
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'($urandom));
    end
    wait_idle("rnd");
    rx_cmp("rnd", 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
